eth_frame_feeder: RTL
=====================

Name: eth_frame_feeder

Overview:
- Buffers a continuous byte stream from the acquisition side into a ping-pong RAM of two FRAME_LEN-byte frames, all in the gmii_tx_clk domain.
- Presents each complete frame to the UDP transmit controller on the data_to_eth, valid_to_eth, counter_to_eth and ready_to_eth interface.
- Sequence per frame: assert ready_to_eth, wait a fixed gap so the controller reaches its RAM-write state, then burst FRAME_LEN bytes with a running 1-based byte counter.

Parameters:
- FRAME_LEN, 1004, bytes per frame; legal range 2..1023; equals the controller's udp_send_data_length.
- READY_HOLD, 8, cycles ready_to_eth is held high; must be ≥4 because the consumer edge-detects through a 4-deep pipeline.
- START_GAP, 256, cycles from ready_to_eth deassertion to the first valid byte.
- MIN_IDLE, 32, minimum cycles between the last byte of one burst and the next ready_to_eth rise.

Ports:
- gmii_tx_clk  in  1  clock for all logic.
- rst_n  in  1  reset: asynchronous, active-low.
- s_data  in  8  input sample byte.
- s_valid  in  1  s_data is valid this cycle.
- s_ready  out  1  feeder can accept a byte; a byte is accepted when s_valid&&s_ready.
- data_to_eth  out  8  frame byte, registered.
- valid_to_eth  out  1  data_to_eth valid, registered.
- counter_to_eth  out  10  1-based index of the byte on data_to_eth; 0 when not valid.
- ready_to_eth  out  1  frame-available strobe, held READY_HOLD cycles.
- overflow  out  1  sticky: at least one byte was dropped.
- ovf_clr  in  1  synchronous clear of overflow.
- frames_sent  out  16  count of completed bursts; wraps at 65535→0.

Behaviour:
- Reset values:
  - data_to_eth=0, valid_to_eth=0, counter_to_eth=0, ready_to_eth=0, overflow=0, frames_sent=0.
  - Both buffers empty, wr_buf=0, wr_addr=0, rd state IDLE; s_ready=1 immediately after reset.
- Write side:
  - On an accepted byte, write RAM[wr_buf][wr_addr] and increment wr_addr.
  - When wr_addr==FRAME_LEN-1 is accepted: set full[wr_buf], record that buffer as the oldest if no other frame is queued, toggle wr_buf, clear wr_addr.
- s_ready = ~full[wr_buf], combinational from state flops.
- Drops: s_valid while s_ready=0 sets overflow; the byte is dropped and wr_addr is unchanged.
- overflow: ovf_clr clears it; if a drop and ovf_clr occur in the same cycle, the drop wins and overflow stays 1.
- Read FSM states and transitions:
  - IDLE: leave when a full buffer exists and idle_cnt≥MIN_IDLE. Select rd_buf = oldest full buffer (strict FIFO order) and go to READY.
  - READY: ready_to_eth=1 for exactly READY_HOLD cycles, then GAP.
  - GAP: ready_to_eth=0; count START_GAP cycles, then STREAM.
  - STREAM: issue reads RAM[rd_buf][0..FRAME_LEN-1] on consecutive cycles with no bubbles; RAM has 1-cycle read latency. Outputs are registered, so the first valid byte appears 2 cycles after STREAM entry. Byte k (1..FRAME_LEN) appears with counter_to_eth=k and valid_to_eth=1. After the last read, go to DONE.
  - DONE: wait for the final output cycle to drain, then clear full[rd_buf], increment frames_sent, reset idle_cnt, go to IDLE.
- valid_to_eth is high for exactly FRAME_LEN consecutive cycles per frame. counter_to_eth returns to 0 the cycle after byte FRAME_LEN. data_to_eth=0 whenever valid is low.
- idle_cnt saturates at MIN_IDLE and counts from reset, so the first frame is not delayed beyond MIN_IDLE.
- Same-cycle events: if full[rd_buf] clears in DONE while the writer is blocked on that buffer, s_ready rises the next cycle and no byte is lost. Completing a write-buffer fill in the same cycle as a read-buffer release is legal and both take effect.
- Writing into the non-read buffer during READY, GAP or STREAM is always permitted.
- rst_n mid-burst: outputs go to reset values asynchronously, and all buffered data is discarded.

Test Plan:
- Feed 1004 bytes 0x00..0xEB (mod 256) continuously → after MIN_IDLE: ready_to_eth high 8 cycles, then 256 idle cycles, then 1004 consecutive valid bytes with counter 1..1004 and data matching input; frames_sent=1.
- Feed 3×1004 bytes back-to-back at full rate → s_ready drops only while both buffers are full; three bursts in input order, each separated by ≥32 idle cycles; overflow=0; frames_sent=3.
- Hold s_valid=1 continuously with both buffers full → overflow=1, the frame in progress is unchanged; pulse ovf_clr → overflow=0.
- Drive ovf_clr in the same cycle as a drop → overflow stays 1.
- Assert rst_n low at counter_to_eth=500 → valid, ready and counter are 0 immediately; after release no burst occurs until a new 1004 bytes have been written.
- Feed 1003 bytes and stop → ready_to_eth never asserts; feed 1 more byte → a burst starts.

Source files
------------

// File: rtl/eth_frame_feeder_if.sv
// ---------------------------------------------------------------------------
// eth_frame_feeder_if
//
// Bundles every non-clock/reset signal of the frame feeder.
//   Acquisition side : s_data, s_valid (into feeder), s_ready (out of feeder)
//   Ethernet side    : data_to_eth, valid_to_eth, counter_to_eth, ready_to_eth
//   Status/control   : overflow, frames_sent (out), ovf_clr (in)
// The master modport is the feeder's own view. The slave modport is the view
// of whatever surrounds it: the sample source, the UDP controller and the
// status logic.
// ---------------------------------------------------------------------------
interface eth_frame_feeder_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  data_to_eth;
    logic        valid_to_eth;
    logic [9:0]  counter_to_eth;
    logic        ready_to_eth;
    logic        overflow;
    logic        ovf_clr;
    logic [15:0] frames_sent;

    modport master (
        input  s_data, s_valid, ovf_clr,
        output s_ready, data_to_eth, valid_to_eth, counter_to_eth,
               ready_to_eth, overflow, frames_sent
    );

    modport slave (
        output s_data, s_valid, ovf_clr,
        input  s_ready, data_to_eth, valid_to_eth, counter_to_eth,
               ready_to_eth, overflow, frames_sent
    );
endinterface

// File: rtl/eth_frame_feeder.sv
// ---------------------------------------------------------------------------
// eth_frame_feeder
//
// Collects a continuous byte stream into a two-frame ping-pong RAM. Each
// complete frame is handed to the UDP transmit controller as follows. The
// feeder raises ready_to_eth for a short strobe. It then waits long enough
// for the controller to reach its RAM-write state. Finally it bursts the
// frame with a running 1-based byte counter.
//
// Ports:
//   gmii_tx_clk : clock for all logic
//   rst_n       : asynchronous, active-low reset
//   feed_if     : eth_frame_feeder_if.master. It carries the sample input
//                 handshake, the Ethernet-side frame interface, the sticky
//                 overflow flag with its clear, and the sent-frame counter.
// ---------------------------------------------------------------------------
module eth_frame_feeder #(
    parameter int FRAME_LEN  = 1004,
    parameter int READY_HOLD = 8,
    parameter int START_GAP  = 256,
    parameter int MIN_IDLE   = 32
) (
    input  logic                gmii_tx_clk,
    input  logic                rst_n,
    eth_frame_feeder_if.master  feed_if
);

    localparam logic [9:0]  LAST_ADDR = 10'(FRAME_LEN - 1);
    localparam logic [15:0] HOLD_LAST = 16'(READY_HOLD - 1);
    // The read pipeline adds two cycles between entering STREAM and the first
    // valid byte. GAP is therefore shortened by two cycles. This keeps the
    // first valid byte exactly START_GAP cycles after ready_to_eth falls.
    localparam logic [15:0] GAP_LAST  = 16'(START_GAP - 3);
    localparam logic [15:0] IDLE_SAT  = 16'(MIN_IDLE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_GAP,
        ST_STREAM,
        ST_DONE
    } rd_state_e;

    // Frame storage: index 0 selects the buffer, index 1 selects the byte.
    logic [7:0]  ram [2][FRAME_LEN];
    logic [7:0]  rdata_q;

    // Write-side state
    logic        wr_buf_q,  wr_buf_d;
    logic [9:0]  wr_addr_q, wr_addr_d;
    logic [1:0]  full_q,    full_d;
    logic        oldest_q,  oldest_d;
    logic        overflow_q, overflow_d;
    logic [15:0] frames_q,  frames_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;

    // Read-side state
    rd_state_e   state_q,   state_d;
    logic        rd_buf_q,  rd_buf_d;
    logic [9:0]  rd_addr_q, rd_addr_d;
    logic [15:0] timer_q,   timer_d;
    logic        rd_vld_q;
    logic [9:0]  rd_idx_q;

    // Registered outputs
    logic [7:0]  data_q;
    logic        valid_q;
    logic [9:0]  counter_q;
    logic        ready_q,   ready_d;

    logic        accept, drop, fill, other_busy;
    logic        rd_en, release_buf;

    assign feed_if.s_ready        = ~full_q[wr_buf_q];
    assign feed_if.data_to_eth    = data_q;
    assign feed_if.valid_to_eth   = valid_q;
    assign feed_if.counter_to_eth = counter_q;
    assign feed_if.ready_to_eth   = ready_q;
    assign feed_if.overflow       = overflow_q;
    assign feed_if.frames_sent    = frames_q;

    // Write side. Accepted bytes fill the current write buffer. Completing a
    // buffer marks it full and flips to the other buffer. The oldest pointer
    // always names the full buffer that must be sent next. A drop outranks a
    // simultaneous overflow clear.
    always_comb begin
        accept     = feed_if.s_valid && feed_if.s_ready;
        drop       = feed_if.s_valid && !feed_if.s_ready;
        fill       = accept && (wr_addr_q == LAST_ADDR);
        wr_addr_d  = wr_addr_q;
        wr_buf_d   = wr_buf_q;
        full_d     = full_q;
        oldest_d   = oldest_q;
        overflow_d = overflow_q;
        frames_d   = frames_q;
        idle_cnt_d = idle_cnt_q;
        other_busy = full_q[~wr_buf_q] && !(release_buf && (rd_buf_q == ~wr_buf_q));

        if (accept) begin
            wr_addr_d = fill ? 10'd0 : wr_addr_q + 10'd1;
        end
        if (release_buf) begin
            full_d[rd_buf_q] = 1'b0;
            frames_d         = frames_q + 16'd1;
        end
        if (fill) begin
            full_d[wr_buf_q] = 1'b1;
            wr_buf_d         = ~wr_buf_q;
        end

        if (fill && !other_busy) begin
            oldest_d = wr_buf_q;
        end else if (release_buf && full_q[~rd_buf_q]) begin
            oldest_d = ~rd_buf_q;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (feed_if.ovf_clr) begin
            overflow_d = 1'b0;
        end

        if (release_buf) begin
            idle_cnt_d = 16'd0;
        end else if (idle_cnt_q < IDLE_SAT) begin
            idle_cnt_d = idle_cnt_q + 16'd1;
        end
    end

    // Read sequencer. It strobes ready, waits out the gap, then streams one
    // RAM read per cycle. Finally it releases the buffer once the last read
    // has left the RAM stage, so the output register already holds the last
    // byte.
    always_comb begin
        state_d     = state_q;
        rd_buf_d    = rd_buf_q;
        rd_addr_d   = rd_addr_q;
        timer_d     = timer_q;
        rd_en       = 1'b0;
        release_buf = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((|full_q) && (idle_cnt_q >= IDLE_SAT)) begin
                    state_d  = ST_READY;
                    rd_buf_d = oldest_q;
                    timer_d  = 16'd0;
                end
            end
            ST_READY: begin
                if (timer_q == HOLD_LAST) begin
                    state_d = ST_GAP;
                    timer_d = 16'd0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (timer_q == GAP_LAST) begin
                    state_d   = ST_STREAM;
                    rd_addr_d = 10'd0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_STREAM: begin
                rd_en = 1'b1;
                if (rd_addr_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                end else begin
                    rd_addr_d = rd_addr_q + 10'd1;
                end
            end
            ST_DONE: begin
                if (!rd_vld_q) begin
                    release_buf = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_READY);
    end

    // Frame RAM: one write port from the acquisition side and one
    // registered read port for the sequencer. It has no reset; the full
    // flags alone decide what is valid.
    always_ff @(posedge gmii_tx_clk) begin
        if (accept) begin
            ram[wr_buf_q][wr_addr_q] <= feed_if.s_data;
        end
        if (rd_en) begin
            rdata_q <= ram[rd_buf_q][rd_addr_q];
        end
    end

    // All control state and registered outputs. Reset discards buffered
    // frames by clearing the full flags.
    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_buf_q   <= 1'b0;
            wr_addr_q  <= 10'd0;
            full_q     <= 2'b00;
            oldest_q   <= 1'b0;
            overflow_q <= 1'b0;
            frames_q   <= 16'd0;
            idle_cnt_q <= 16'd0;
            state_q    <= ST_IDLE;
            rd_buf_q   <= 1'b0;
            rd_addr_q  <= 10'd0;
            timer_q    <= 16'd0;
            rd_vld_q   <= 1'b0;
            rd_idx_q   <= 10'd0;
            data_q     <= 8'd0;
            valid_q    <= 1'b0;
            counter_q  <= 10'd0;
            ready_q    <= 1'b0;
        end else begin
            wr_buf_q   <= wr_buf_d;
            wr_addr_q  <= wr_addr_d;
            full_q     <= full_d;
            oldest_q   <= oldest_d;
            overflow_q <= overflow_d;
            frames_q   <= frames_d;
            idle_cnt_q <= idle_cnt_d;
            state_q    <= state_d;
            rd_buf_q   <= rd_buf_d;
            rd_addr_q  <= rd_addr_d;
            timer_q    <= timer_d;
            rd_vld_q   <= rd_en;
            rd_idx_q   <= rd_addr_q + 10'd1;
            data_q     <= rd_vld_q ? rdata_q : 8'd0;
            valid_q    <= rd_vld_q;
            counter_q  <= rd_vld_q ? rd_idx_q : 10'd0;
            ready_q    <= ready_d;
        end
    end

endmodule
